// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: parameter defaults,
// the instruction word width and the loader state encoding.
package imem_loader_pkg;

  localparam int unsigned DEF_DEPTH    = 64;
  localparam int unsigned DEF_AW       = 6;
  localparam int unsigned DEF_RST_HOLD = 4;
  localparam int unsigned WORD_W       = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_ERR
  } state_e;

endpackage

// File: rtl/imem_loader_holdctr.sv
// CPU-reset hold counter. A start pulse arms the counter; expired is high on
// the RST_HOLD-th cycle after start, counting the first cycle as 1, so a
// state entered on the start edge lasts exactly RST_HOLD cycles.
module imem_loader_holdctr
  import imem_loader_pkg::*;
#(
  parameter int unsigned RST_HOLD = DEF_RST_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic expired
);

  localparam int unsigned CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  // Arm on start, count down while running, disarm once expired.
  always_comb begin
    expired = run_q && (cnt_q == '0);
    cnt_d   = cnt_q;
    run_d   = run_q;
    if (start) begin
      cnt_d = CW'(RST_HOLD - 1);
      run_d = 1'b1;
    end else if (expired) begin
      run_d = 1'b0;
    end else if (run_q) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a stream of instruction words, writes
// them to consecutive imem addresses, then holds the CPU in reset for
// RST_HOLD cycles before releasing it. Overflow past DEPTH words is an error.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- the in_last word is an
// XOR checksum of the preceding words and is not written to memory.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned RST_HOLD = DEF_RST_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              imem_we,
  output logic [AW-1:0]     imem_waddr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  // One extra bit so the count never wraps back onto address 0.
  localparam logic [AW:0] LAST_ADDR = (AW + 1)'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [AW:0]       count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic              we_q, we_d;
  logic [AW-1:0]     waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hold_start;
  logic              hold_expired;
  logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] xor_q, xor_d;
`endif

  assign accept = in_valid && in_ready_q;

  imem_loader_holdctr #(
    .RST_HOLD (RST_HOLD)
  ) u_holdctr (
    .clk     (clk),
    .rst     (rst),
    .start   (hold_start),
    .expired (hold_expired)
  );

  // Next-state, write-port and status computation; outputs are registered
  // from the next state so they line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    hold_start = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (load_start) begin
          state_d = S_LOAD;
          count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      S_LOAD: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (in_last) begin
            if (in_data == xor_q) begin
              state_d    = S_HOLD;
              hold_start = 1'b1;
            end else begin
              state_d = S_ERR;
            end
          end else begin
            we_d    = 1'b1;
            waddr_d = count_q[AW-1:0];
            wdata_d = in_data;
            count_d = count_q + (AW + 1)'(1);
            xor_d   = xor_q ^ in_data;
            if (count_q == LAST_ADDR) begin
              state_d = S_ERR;
            end
          end
`else
          we_d    = 1'b1;
          waddr_d = count_q[AW-1:0];
          wdata_d = in_data;
          count_d = count_q + (AW + 1)'(1);
          if (in_last) begin
            state_d    = S_HOLD;
            hold_start = 1'b1;
          end else if (count_q == LAST_ADDR) begin
            state_d = S_ERR;
          end
`endif
        end
      end
      S_HOLD: begin
        if (hold_expired) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_LOAD);
    cpu_rst_d  = (state_d != S_RUN);
    done_d     = (state_d == S_RUN);
    err_d      = (state_d == S_ERR);
  end

  // State and registered outputs; reset forces IDLE and cancels any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a per-cycle vector table for the basic
// load / hold / run / reload flow, plus hand-written sequences for a gappy
// source, overflow, reset mid-load and (with IMEM_LOADER_CHECKSUM_EN) checksums.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int unsigned DEPTH    = 64;
  localparam int unsigned AW       = 6;
  localparam int unsigned RST_HOLD = 4;
  localparam int unsigned NVEC     = 15;

  logic              clk;
  logic              rst;
  logic              load_start;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              in_last;
  logic              imem_we;
  logic [AW-1:0]     imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct {
    logic          ls;
    logic          v;
    logic [31:0]   d;
    logic          last;
    logic          we;
    logic [AW-1:0] a;
    logic [31:0]   wd;
    logic          rdy;
    logic          cr;
    logic          dn;
    logic          er;
  } vec_t;

  vec_t tbl[NVEC];

  imem_loader #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .RST_HOLD (RST_HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Status bits, plus write address/data only when a write is expected.
  function automatic logic [63:0] pack(input logic we, rdy, cr, dn, er,
                                       input logic [AW-1:0] a, input logic [31:0] d,
                                       input logic with_wr);
    return {21'd0, we, rdy, cr, dn, er, (with_wr ? a : 6'd0), (with_wr ? d : 32'd0)};
  endfunction

  function automatic logic [63:0] obs(input logic with_wr);
    return pack(imem_we, in_ready, cpu_rst, done, err, imem_waddr, imem_wdata, with_wr);
  endfunction

  function automatic vec_t mk(input logic ls, v, input logic [31:0] d, input logic last,
                              input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                              input logic rdy, cr, dn, er);
    vec_t r;
    r.ls = ls; r.v = v; r.d = d; r.last = last;
    r.we = we; r.a = a; r.wd = wd; r.rdy = rdy; r.cr = cr; r.dn = dn; r.er = er;
    return r;
  endfunction

  task automatic drive(input logic ls, v, input logic [31:0] d, input logic last);
    load_start = ls;
    in_valid   = v;
    in_data    = d;
    in_last    = last;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_done(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    logic [31:0] words[8];
    logic [31:0] cs;
    int          sent;
    int          nwr;
    int          exp_wr;
    logic        v;
    logic        acc;
    logic        ok;

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 1'b0);

    // Basic flow: load 3 words, hold, run, ignored inputs, reload of 1 word.
    //             ls    v     data          last  we    a  wdata         rdy   cr    dn    er
    tbl[0]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 32'h00A00093, 1'b0, 1'b1, 0, 32'h00A00093, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 32'h00108113, 1'b0, 1'b1, 1, 32'h00108113, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    tbl[3]  = mk(1'b0, 1'b1, 32'h00B08180, 1'b1, 1'b0, 0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0);
`else
    tbl[3]  = mk(1'b0, 1'b1, 32'h002081B3, 1'b1, 1'b1, 2, 32'h002081B3, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
    tbl[4]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0);
    tbl[9]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    tbl[10] = mk(1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0);
`else
    tbl[10] = mk(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
    tbl[11] = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0);
    tbl[13] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0);

    // Reset values, sampled while rst is held.
    step();
    chk("reset_vals", obs(1'b1), pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1));
    do_reset();

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(tbl[i].ls, tbl[i].v, tbl[i].d, tbl[i].last);
      step();
      chk($sformatf("vec%0d", i), obs(tbl[i].we),
          pack(tbl[i].we, tbl[i].rdy, tbl[i].cr, tbl[i].dn, tbl[i].er, tbl[i].a, tbl[i].wd, tbl[i].we));
    end

    // Source with a bubble every other cycle; garbage on the bus when idle.
    do_reset();
    cs = '0;
    for (int i = 0; i < 7; i++) begin
      words[i] = 32'h1000_0000 + 32'(i) * 32'h111;
      cs = cs ^ words[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    words[7] = cs;
    exp_wr = 7;
`else
    words[7] = 32'h1000_0777;
    exp_wr = 8;
`endif
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    step();
    sent = 0;
    nwr  = 0;
    for (int c = 0; c < 40 && sent < 8; c++) begin
      v = (c % 2 == 0);
      if (v) drive(1'b0, 1'b1, words[sent], (sent == 7));
      else   drive(1'b0, 1'b0, 32'hBAD0BAD0, 1'b1);
      acc = v && in_ready;
      step();
      if (acc) sent++;
      if (imem_we) begin
        chk("alt_addr", 64'(imem_waddr), 64'(nwr));
        chk("alt_data", 64'(imem_wdata), (nwr < 8) ? 64'(words[nwr]) : 64'hX);
        nwr++;
      end
    end
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    chk("alt_sent", 64'(sent), 64'd8);
    chk("alt_nwr", 64'(nwr), 64'(exp_wr));
    wait_done(10, ok);
    chk("alt_done", 64'(ok), 64'd1);

    // Overflow: DEPTH words with no in_last.
    do_reset();
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    step();
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive(1'b0, 1'b1, 32'hA500_0000 | 32'(i), 1'b0);
      step();
      chk($sformatf("ovf_wr%0d", i), obs(1'b1),
          pack(1'b1, (i != int'(DEPTH) - 1), 1'b1, 1'b0, (i == int'(DEPTH) - 1),
               6'(i), 32'hA500_0000 | 32'(i), 1'b1));
    end
    step();
    chk("ovf_no_extra_wr", obs(1'b0), pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 32'd0, 1'b0));
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    step();
    chk("ovf_restart", obs(1'b0), pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0));
    drive(1'b0, 1'b1, 32'h12345678, 1'b0);
    step();
    chk("ovf_restart_wr", obs(1'b1), pack(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 32'h12345678, 1'b1));

    // Reset in the middle of a load.
    do_reset();
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    step();
    drive(1'b0, 1'b1, 32'hCAFE0000, 1'b0);
    step();
    drive(1'b0, 1'b1, 32'hCAFE0001, 1'b0);
    step();
    chk("rstmid_wr1", obs(1'b1), pack(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1, 32'hCAFE0001, 1'b1));
    rst = 1'b1;
    drive(1'b0, 1'b1, 32'hCAFE0002, 1'b0);
    step();
    chk("rstmid_vals", obs(1'b1), pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1));
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    step();
    chk("rst_over_start", obs(1'b1), pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1));
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'hCAFE0003, 1'b0);
    step();
    chk("idle_ignores_valid", obs(1'b1), pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1));

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Matching checksum: two writes, checksum not written, then run.
    do_reset();
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    step();
    nwr = 0;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive(1'b0, 1'b1, 32'h11111111, 1'b0);
        1: drive(1'b0, 1'b1, 32'h22222222, 1'b0);
        default: drive(1'b0, 1'b1, 32'h33333333, 1'b1);
      endcase
      step();
      if (imem_we) nwr++;
    end
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    chk("cs_ok_nwr", 64'(nwr), 64'd2);
    wait_done(10, ok);
    chk("cs_ok_done", 64'(ok), 64'd1);

    // Bad checksum: error, checksum not written.
    do_reset();
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    step();
    drive(1'b0, 1'b1, 32'h11111111, 1'b0);
    step();
    drive(1'b0, 1'b1, 32'h22222222, 1'b0);
    step();
    drive(1'b0, 1'b1, 32'h33333334, 1'b1);
    step();
    chk("cs_bad", obs(1'b0), pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 32'd0, 1'b0));
    drive(1'b0, 1'b0, 32'd0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter DEPTH, default 64, SHALL set the number of instruction-memory words.
REQ-003 Parameter AW, default 6, SHALL set the address width, equal to log2(DEPTH).
REQ-004 Parameter RST_HOLD, default 4, SHALL set the number of cycles the CPU reset is held after a load, minimum 1.
REQ-005 Ports, as name direction width meaning, SHALL be:
- clk in 1: clock.
- rst in 1: synchronous active-high reset.
- load_start in 1: single-cycle request to begin a load.
- in_valid in 1: source word valid.
- in_ready out 1: loader can accept a word.
- in_data in 32: instruction word.
- in_last in 1: final word of the image.
- imem_we out 1: instruction-memory write strobe.
- imem_waddr out AW: word address.
- imem_wdata out 32: write data.
- cpu_rst out 1: reset to the 5-stage pipeline, active-high.
- done out 1: image loaded and CPU running.
- err out 1: load failed.

Function
REQ-006 The FSM SHALL have the states IDLE, LOAD, HOLD, RUN and ERR.
REQ-007 In IDLE, in_ready SHALL be 0 and cpu_rst SHALL be 1, and load_start SHALL move the FSM to LOAD on the next edge.
REQ-008 In LOAD, in_ready SHALL be 1.
REQ-009 A word SHALL be accepted on an edge where in_valid and in_ready are both 1.
REQ-010 On the cycle after an accepted word, imem_we SHALL be 1, imem_waddr SHALL be the word count, imem_wdata SHALL be the accepted in_data, and the count SHALL then increment (latency 1).
REQ-011 imem_we SHALL be 0 on every cycle that does not follow an accepted write.
REQ-012 When the accepted word has in_last=1, the FSM SHALL go to HOLD.
REQ-013 When the word accepted at address DEPTH-1 has in_last=0, that word SHALL be written and the FSM SHALL go to ERR (overflow, no address wrap).
REQ-014 In HOLD, cpu_rst SHALL stay 1 for exactly RST_HOLD cycles, after which the FSM SHALL go to RUN.
REQ-015 In RUN, cpu_rst SHALL be 0 and done SHALL be 1.
REQ-016 load_start in RUN or ERR SHALL go to LOAD, with cpu_rst=1 asserted from the next cycle and done, err and the count cleared.
REQ-017 load_start in LOAD or HOLD SHALL be ignored.
REQ-018 In ERR, err SHALL be 1, cpu_rst SHALL be 1 and in_ready SHALL be 0.
REQ-019 in_valid while in_ready=0 SHALL have no effect.

Reset
REQ-020 rst SHALL force IDLE, and SHALL do so mid-load with no further writes issued.
REQ-021 Under reset, outputs SHALL be cpu_rst=1, in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, done=0 and err=0, and the count SHALL be 0.
REQ-022 rst SHALL take priority over load_start in the same cycle.

Configuration
REQ-023 With macro IMEM_LOADER_CHECKSUM_EN defined, the in_last word SHALL be a checksum word that is not written to memory.
REQ-024 With the macro defined, the checksum word SHALL be compared to the XOR of all prior words of the load: a match SHALL go to HOLD, and a mismatch SHALL go to ERR.
REQ-025 With the macro defined, a checksum word arriving as the first word SHALL be compared against 0.
REQ-026 With the macro defined, the overflow rule SHALL apply to data words only.
REQ-027 Without the macro, the in_last word SHALL be an ordinary instruction word, written per REQ-010.

Structure
REQ-028 Package imem_loader_pkg SHALL hold the state enumeration, the DEPTH, AW and RST_HOLD defaults, and the 32-bit word-width constant.
REQ-029 The cycle counter used for HOLD SHALL be a sub-module, imem_loader_holdctr, with inputs clk, rst and start and output expired.

Verification
REQ-030 Reset, then load_start, then 3 words 0x00A00093, 0x00108113, 0x002081B3 (last on the 3rd), macro off -> writes at addresses 0, 1, 2, then cpu_rst high exactly 4 cycles, then done=1.
REQ-031 A source that deasserts in_valid every other cycle -> no duplicate or missing writes, and addresses are contiguous.
REQ-032 64 words with no in_last -> 64 writes (last at address 63), then err=1, cpu_rst=1 and in_ready=0; a following load_start clears err.
REQ-033 rst asserted after 2 of 5 words -> IDLE, imem_we=0 from the next cycle, and all REQ-021 values hold.
REQ-034 Macro on: words 0x11111111, 0x22222222 then checksum 0x33333333 -> 2 writes, then done=1.
REQ-035 Macro on: checksum 0x33333334 -> ERR with no write of the checksum word.
